// File: rtl/onehot_bit_scanner_if.sv
// Handshake bundle for onehot_bit_scanner: word input channel and beat output channel.
// The scanner uses the slave modport; the producer/consumer side uses master.
interface onehot_bit_scanner_if #(
    parameter int Width = 32
);
    localparam int IdxWidth = $clog2(Width);

    logic                in_valid_i;
    logic                in_ready_o;
    logic [Width-1:0]    in_bits_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [IdxWidth-1:0] out_idx_o;
    logic [Width-1:0]    out_mask_o;
    logic                out_last_o;
    logic                out_empty_o;
    logic [IdxWidth:0]   out_cnt_o;

    modport slave (
        input  in_valid_i, in_bits_i, out_ready_i,
        output in_ready_o, out_valid_o, out_idx_o, out_mask_o,
               out_last_o, out_empty_o, out_cnt_o
    );

    modport master (
        output in_valid_i, in_bits_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_idx_o, out_mask_o,
               out_last_o, out_empty_o, out_cnt_o
    );
endinterface

// File: rtl/onehot_bit_scanner.sv
// Accepts a word and emits one beat per set bit, lowest first, each carrying the
// bit position, its one-hot mask and its ordinal; a zero word yields one empty beat.
module onehot_bit_scanner #(
    parameter int Width = 32
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    onehot_bit_scanner_if.slave bus
);
    localparam int IdxWidth = $clog2(Width);
    localparam int CntWidth = IdxWidth + 1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e              state_q, state_d;
    logic [Width-1:0]    rem_q, rem_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                empty_q, empty_d;

    logic [IdxWidth-1:0] idx;
    logic [Width-1:0]    mask;
    logic                last;

    // Two's-complement trick isolates the lowest set bit; zero stays zero.
    assign mask = rem_q & (~rem_q + Width'(1));
    assign last = empty_q || ((rem_q & (rem_q - Width'(1))) == '0);

    always_comb begin
        idx = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (rem_q[i]) idx = IdxWidth'(i);
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        empty_d = empty_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    rem_d   = bus.in_bits_i;
                    cnt_d   = '0;
                    empty_d = (bus.in_bits_i == '0);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_ready_i) begin
                    rem_d = rem_q & ~mask;
                    cnt_d = cnt_q + CntWidth'(1);
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
        end
    end

    // Handshake flags decode from state alone; no input reaches them combinationally.
    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == SCAN);
    assign bus.out_idx_o   = idx;
    assign bus.out_mask_o  = mask;
    assign bus.out_last_o  = last;
    assign bus.out_empty_o = empty_q;
    assign bus.out_cnt_o   = cnt_q;
endmodule

// File: doc/onehot_bit_scanner.md
# onehot_bit_scanner

Sequential bit-scanner that accepts a multi-bit word over a valid/ready handshake and emits one beat per set bit, lowest first. Each beat carries the bit position and its one-hot mask (`1 << position`). It sits directly downstream of the constant one-hot/bit-mask producers in the SVase test designs. It turns a packed bit vector (e.g. `32'd43758`) into a stream of single-bit events for consumers that handle one request at a time.

## Interface
- `Width`, default 32: input word width; must be ≥ 2.
- `IdxWidth`, default `$clog2(Width)`: width of the position output; derived, not overridden.
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  1  input word valid.
- `in_ready_o`  out  1  scanner can accept a word.
- `in_bits_i`  in  Width  word to scan.
- `out_valid_o`  out  1  output beat valid.
- `out_ready_i`  in  1  consumer accepts beat.
- `out_idx_o`  out  IdxWidth  position of the lowest remaining set bit.
- `out_mask_o`  out  Width  one-hot mask of `out_idx_o`.
- `out_last_o`  out  1  this beat is the final beat for the current word.
- `out_empty_o`  out  1  input word was zero; the beat carries no bit.
- `out_cnt_o`  out  IdxWidth+1  ordinal of the beat within the word, starting at 0.

## Operation
- Two states: IDLE and SCAN.
- IDLE:
  - `in_ready_o = 1`, `out_valid_o = 0`.
  - On `in_valid_i && in_ready_o`: register `in_bits_i` into `rem_q`, clear `cnt_q`, set `empty_q = (in_bits_i == 0)`, then go to SCAN.
- SCAN:
  - `in_ready_o = 0`, `out_valid_o = 1`.
  - `out_idx_o` = position of the lowest set bit of `rem_q`, from a combinational priority encoder.
  - `out_mask_o = rem_q & (~rem_q + 1)`. This must equal `1 << out_idx_o`.
  - `out_last_o = empty_q || ((rem_q & (rem_q - 1)) == 0)`.
  - `out_cnt_o = cnt_q`.
  - Empty word: a single beat with `out_empty_o = 1`, `out_last_o = 1`, `out_idx_o = 0`, `out_mask_o = 0`.
  - On `out_valid_o && out_ready_i`:
    - `rem_q <= rem_q & ~out_mask_o`.
    - `cnt_q <= cnt_q + 1`.
    - If `out_last_o`, return to IDLE.
  - While `out_ready_i = 0`, all `out_*` outputs stay stable (AXI-style: valid is never withdrawn and the payload never changes).
- Arithmetic:
  - `cnt_q` has `IdxWidth+1` bits, so `cnt = Width-1` is representable.
  - `~rem_q + 1` and `rem_q - 1` are computed at `Width` bits. Wrap-around is harmless because `rem_q != 0` whenever the non-empty path is used.
- `in_valid_i` seen while in SCAN is ignored; that word is not captured.
- Mid-operation reset (`rst_ni` low in any state): the current word is abandoned and no further beats are emitted.

## Timing
- Reset values:
  - state = IDLE, `rem_q = 0`, `cnt_q = 0`, `empty_q = 0`.
  - `in_ready_o = 1`, `out_valid_o = 0`, `out_idx_o = 0`, `out_mask_o = 0`, `out_last_o = 1`, `out_empty_o = 0`, `out_cnt_o = 0`.
- Input accepted at edge N: first beat is valid in cycle N+1, so latency is 1 cycle.
- With `out_ready_i` held high, a word with k set bits produces beats in cycles N+1 … N+k; a zero word produces one beat.
- After the last beat is accepted at edge M, `in_ready_o = 1` in cycle M+1.
- Steady-state throughput: k+1 cycles per word, including one idle cycle; a zero word takes 2 cycles.
- No combinational path from `out_ready_i` or `in_valid_i` to `in_ready_o` or `out_valid_o`; both are decoded from state only.

## Test plan
- Reset, then hold `rst_ni` low → all outputs at the reset values above; `in_ready_o = 1`.
- Drive `in_bits_i = 32'd43758` (0xAAEE) with `out_ready_i = 1` → 10 beats in consecutive cycles:
  - idx 1,2,3,5,6,7,9,11,13,15; masks 0x2 … 0x8000; `out_cnt_o` 0…9.
  - `out_last_o` high only on idx 15; `in_ready_o` high one cycle after that beat.
- Drive `32'd32` then `32'd4096` back-to-back → single beats {idx 5, mask 0x20, last} then {idx 12, mask 0x1000, last}; the second word is accepted only while in IDLE.
- Drive `32'd0` → one beat with `out_empty_o = 1`, `out_last_o = 1`, mask 0, idx 0; then IDLE.
- Drive `32'hFFFF_FFFF` with random `out_ready_i` stalls → 32 beats; payload stable during stalls; final beat idx 31, mask 0x8000_0000, cnt 31, last.
- Assert `rst_ni` low during beat 3 of 0xAAEE → `out_valid_o` drops asynchronously; after release the scanner is in IDLE and the next word scans from its own lowest bit with cnt 0.
